des_crypt_core: RTL and testbench

Parametrised, handshaked DES engine. It is the next generation of the team's single-shot DES block and adds an encrypt/decrypt mode and on-the-fly key schedule. The number of Feistel rounds evaluated per clock is configurable, and valid/ready flow control is provided on both sides. It sits between the host command interface and the output buffer, and processes one 64-bit block at a time per FIPS 46-3.

---
 rtl/des_crypt_core.sv | 271 +++++++++++++++++++++++++++
 tb/tb_des_crypt_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_crypt_core.sv
// Handshaked DES engine (FIPS 46-3) with encrypt/decrypt and an on-the-fly key schedule.
// ROUNDS_PER_CYCLE Feistel rounds are unrolled per clock; only C/D is kept, no subkey storage.
module des_crypt_core #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        decrypt,
   input  logic [63:0] key_in,
   input  logic [63:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] data_out,
   output logic        busy
);

   localparam int unsigned NUM_ITER = 16 / ROUNDS_PER_CYCLE;
   localparam int unsigned CNT_W    = $clog2(NUM_ITER + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ITER - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   generate
      if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
            ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
         $error("des_crypt_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   // Tables list DES bit numbers, bit 1 = MSB of the vector.
   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int unsigned FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int unsigned SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int unsigned i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int unsigned i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int unsigned i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] p;
      logic [5:0]  b;
      for (int unsigned i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ k;
      for (int unsigned j = 0; j < 8; j++) begin
         b = x[47-6*j -: 6];
         s[31-4*j -: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
      end
      for (int unsigned i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
      return p;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[26:0], x[27]};
         2'd2:    return {x[25:0], x[27:26]};
         default: return x;
      endcase
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[0], x[27:1]};
         2'd2:    return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

   // Decrypt walks the encrypt schedule backwards; round 0 taps the PC-1 output unrotated.
   function automatic logic [1:0] shift_amt(input int unsigned rnd, input logic dec);
      if (dec && rnd == 0) return 2'd0;
      if (dec) return (rnd == 1 || rnd == 8 || rnd == 15) ? 2'd1 : 2'd2;
      return (rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 2'd1 : 2'd2;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      l_q, l_d, r_q, r_d;
   logic [27:0]      c_q, c_d, d_q, d_d;
   logic             mode_q, mode_d;
   logic [63:0]      data_out_q, data_out_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [31:0]      l_rnd, r_rnd;
   logic [27:0]      c_rnd, d_rnd;

   always_comb begin
      logic [47:0]  k;
      logic [31:0]  tmp;
      logic [1:0]   sh;
      int unsigned  rnd;
      l_rnd = l_q;
      r_rnd = r_q;
      c_rnd = c_q;
      d_rnd = d_q;
      for (int unsigned u = 0; u < ROUNDS_PER_CYCLE; u++) begin
         rnd = 32'(cnt_q) * ROUNDS_PER_CYCLE + u;
         sh  = shift_amt(rnd, mode_q);
         if (mode_q) begin
            c_rnd = rotr28(c_rnd, sh);
            d_rnd = rotr28(d_rnd, sh);
         end else begin
            c_rnd = rotl28(c_rnd, sh);
            d_rnd = rotl28(d_rnd, sh);
         end
         k     = perm_pc2({c_rnd, d_rnd});
         tmp   = r_rnd;
         r_rnd = l_rnd ^ feistel_f(r_rnd, k);
         l_rnd = tmp;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      l_d        = l_q;
      r_d        = r_q;
      c_d        = c_q;
      d_d        = d_q;
      mode_d     = mode_q;
      data_out_d = data_out_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               {l_d, r_d} = perm_ip(data_in);
               {c_d, d_d} = perm_pc1(key_in);
               mode_d     = decrypt;
               cnt_d      = '0;
               state_d    = S_ROUND;
            end
         end
         S_ROUND: begin
            l_d = l_rnd;
            r_d = r_rnd;
            c_d = c_rnd;
            d_d = d_rnd;
            if (cnt_q == CNT_LAST) begin
               data_out_d = perm_fp({r_rnd, l_rnd});
               state_d    = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_HOLD);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         mode_q      <= 1'b0;
         data_out_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         l_q         <= l_d;
         r_q         <= r_d;
         c_q         <= c_d;
         d_q         <= d_d;
         mode_q      <= mode_d;
         data_out_q  <= data_out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign data_out  = data_out_q;

endmodule

// File: tb/tb_des_crypt_core.sv
// Bench for des_crypt_core: one instance per legal ROUNDS_PER_CYCLE, all driven in lockstep,
// known-answer vectors checked through per-instance expected-result queues.
module tb_des_crypt_core;

   localparam int NI = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        decrypt = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] key_in = '0;
   logic [63:0] data_in = '0;
   logic [NI-1:0] in_ready_v, out_valid_v, busy_v;
   logic [63:0] data_out_v [NI];
   logic [63:0] exp_q [NI][$];
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      des_crypt_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_v[g]),
         .decrypt   (decrypt),
         .key_in    (key_in),
         .data_in   (data_in),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready),
         .data_out  (data_out_v[g]),
         .busy      (busy_v[g])
      );
   end

   typedef struct {
      logic [63:0] key;
      logic [63:0] data;
      logic        dec;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [rpc=%0d]: got %h, expected %h", name, 1 << inst, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, input int i);
      if (exp_q[i].size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL %s [rpc=%0d]: output %h with empty scoreboard", name, 1 << i, data_out_v[i]);
      end else begin
         chk(name, i, data_out_v[i], exp_q[i].pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 50; t++) begin
         if (&in_ready_v) break;
         tick();
      end
      chk("idle wait", 0, 64'(in_ready_v), 64'(5'h1f));
   endtask

   task automatic run_block(input vec_t v, input string name);
      int   lat [NI];
      logic bad [NI];
      wait_idle();
      key_in   = v.key;
      data_in  = v.data;
      decrypt  = v.dec;
      in_valid = 1'b1;
      for (int i = 0; i < NI; i++) begin
         exp_q[i].push_back(v.exp);
         lat[i] = 0;
         bad[i] = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      data_in  = ~v.data;
      key_in   = ~v.key;
      decrypt  = ~v.dec;
      for (int e = 1; e <= 40; e++) begin
         for (int i = 0; i < NI; i++) begin
            if (lat[i] == 0) begin
               if (out_valid_v[i]) lat[i] = e;
               else if (!busy_v[i] || in_ready_v[i]) bad[i] = 1'b1;
            end
         end
         if (&out_valid_v) break;
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < NI; i++) begin
         chk({name, " latency"}, i, 64'(lat[i]), 64'((16 >> i) + 1));
         chk({name, " busy/in_ready while running"}, i, 64'(bad[i]), 64'(0));
         pop_chk(name, i);
      end
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < NI; i++)
         chk({name, " handoff {out_valid,in_ready}"}, i, {62'b0, out_valid_v[i], in_ready_v[i]}, 64'b01);
   endtask

   task automatic backpressure();
      logic bad [NI];
      wait_idle();
      key_in   = vecs[0].key;
      data_in  = vecs[0].data;
      decrypt  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < NI; i++) begin
         exp_q[i].push_back(vecs[0].exp);
         bad[i] = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (&out_valid_v) break;
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         data_in  = {$urandom, $urandom};
         key_in   = {$urandom, $urandom};
         decrypt  = c[1];
         tick();
         for (int i = 0; i < NI; i++)
            if (data_out_v[i] !== 64'h85E813540F0AB405 || !out_valid_v[i] || in_ready_v[i]) bad[i] = 1'b1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < NI; i++) begin
         chk("backpressure hold stable", i, 64'(bad[i]), 64'(0));
         pop_chk("backpressure data", i);
      end
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < NI; i++)
         chk("backpressure release {out_valid,in_ready}", i, {62'b0, out_valid_v[i], in_ready_v[i]}, 64'b01);
   endtask

   task automatic throughput();
      int   last [NI];
      int   nacc [NI];
      logic gap_bad [NI];
      logic iv;
      wait_idle();
      key_in    = 64'h0101010101010101;
      data_in   = '0;
      decrypt   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < NI; i++) begin
         last[i] = -1;
         nacc[i] = 0;
         gap_bad[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 100; cyc++) begin
         iv = (cyc < 70);
         in_valid = iv;
         for (int i = 0; i < NI; i++) begin
            if (iv && in_ready_v[i]) begin
               if (last[i] >= 0 && cyc - last[i] != (16 >> i) + 2) gap_bad[i] = 1'b1;
               last[i] = cyc;
               nacc[i]++;
               exp_q[i].push_back(64'h8CA64DE9C1B123A7);
            end
            if (out_valid_v[i]) pop_chk("throughput data", i);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NI; i++) begin
         chk("throughput accept spacing", i, 64'(gap_bad[i]), 64'(0));
         chk("throughput accept count", i, 64'(nacc[i]), 64'((70 + (16 >> i) + 1) / ((16 >> i) + 2)));
         chk("throughput drained", i, 64'(exp_q[i].size()), 64'(0));
      end
   endtask

   task automatic abort_reset();
      wait_idle();
      key_in   = vecs[0].key;
      data_in  = vecs[0].data;
      decrypt  = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      chk("abort out_valid", 0, 64'(out_valid_v), 64'(0));
      chk("abort busy", 0, 64'(busy_v), 64'(0));
      chk("abort in_ready during reset", 0, 64'(in_ready_v), 64'(0));
      for (int i = 0; i < NI; i++) chk("abort data_out", i, data_out_v[i], 64'(0));
      rst_n = 1'b1;
      tick();
      chk("abort in_ready after release", 0, 64'(in_ready_v), 64'(5'h1f));
      chk("abort out_valid after release", 0, 64'(out_valid_v), 64'(0));
      for (int i = 0; i < NI; i++) exp_q[i].delete();
   endtask

   initial begin
      logic [63:0] fb;
      vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
      vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
      vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
      vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
      vecs[4] = '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815};
      vecs[5] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 1'b1, 64'h4E6F772069732074};
      vecs[6] = '{64'h0101010101010101, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
      vecs[7] = '{64'h0101010101010101, 64'h0000000000000000, 1'b1, 64'h8CA64DE9C1B123A7};
      vecs[8] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0000000000000000};

      repeat (3) tick();
      chk("reset in_ready", 0, 64'(in_ready_v), 64'(0));
      chk("reset out_valid", 0, 64'(out_valid_v), 64'(0));
      chk("reset busy", 0, 64'(busy_v), 64'(0));
      for (int i = 0; i < NI; i++) chk("reset data_out", i, data_out_v[i], 64'(0));
      rst_n = 1'b1;
      tick();
      chk("in_ready after reset release", 0, 64'(in_ready_v), 64'(5'h1f));

      for (int v = 0; v < 9; v++) run_block(vecs[v], $sformatf("vec%0d", v));

      // weak key: a second encryption of the first result returns the plaintext
      run_block(vecs[6], "weak pass1");
      fb = data_out_v[0];
      run_block('{64'h0101010101010101, fb, 1'b0, 64'h0000000000000000}, "weak pass2");

      backpressure();
      throughput();
      abort_reset();
      run_block(vecs[0], "post-abort");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
